// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// I2C target port: synchronised SCL/SDA, START/STOP detection, 7-bit address
// match and an auto-incrementing byte register bridge. SDA is open-drain.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned PTR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [2:0] scl_p, sda_p;
  logic       scl_s, scl_d, sda_s, sda_d;
  logic       rise, fall, start_det, stop_det;

  state_t           state_q, state_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             ph_q, ph_d;
  logic             rw_q, rw_d;
  logic             oe_q, oe_d;
  logic [PTR_W-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;
  logic [7:0]       byte_in;
  logic             last;

  // Idle bus is high, so the synchronisers reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p <= '1;
      sda_p <= '1;
    end else begin
      scl_p <= {scl_p[1:0], scl_in};
      sda_p <= {sda_p[1:0], sda_in};
    end
  end

  assign scl_s = scl_p[1];
  assign scl_d = scl_p[2];
  assign sda_s = sda_p[1];
  assign sda_d = sda_p[2];

  assign rise      = scl_s & ~scl_d;
  assign fall      = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_in = {shreg_q[6:0], sda_s};
  assign last    = (bitcnt_q == 4'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      ph_q     <= 1'b0;
      rw_q     <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      ph_q     <= ph_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ADDR:
          if (rise && last)
            state_d = (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK:
          if (fall && ph_q) state_d = rw_q ? RDATA : PTR;
        PTR:
          if (rise && last) state_d = PTR_ACK;
        PTR_ACK:
          if (fall && ph_q) state_d = WDATA;
        WDATA:
          if (rise && last) state_d = WDATA_ACK;
        WDATA_ACK:
          if (fall && ph_q) state_d = WDATA;
        RDATA:
          if (fall && bitcnt_q == 4'd8) state_d = RDATA_ACK;
        RDATA_ACK:
          if (rise && !ph_q && sda_s) state_d = IDLE;
          else if (fall && ph_q) state_d = RDATA;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    ph_d     = ph_q;
    rw_d     = rw_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    busy_d   = busy_q;
    if (start_det || stop_det) begin
      bitcnt_d = '0;
      ph_d     = 1'b0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA:
          if (rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (last) begin
              bitcnt_d = '0;
              ph_d     = 1'b0;
              if (state_q == ADDR && byte_in[7:1] == DEV_ADDR) begin
                busy_d = 1'b1;
                rw_d   = sda_s;
              end
              if (state_q == PTR) addr_d = PTR_W'(byte_in);
              if (state_q == WDATA) begin
                wdata_d = byte_in;
                wr_d    = 1'b1;
              end
            end
          end
        ADDR_ACK, PTR_ACK, WDATA_ACK:
          if (fall) begin
            oe_d = ~ph_q;
            ph_d = ~ph_q;
            if (ph_q && state_q == WDATA_ACK) addr_d = addr_q + PTR_ONE;
            // First read bit goes out on the same fall that ends the ACK
            if (ph_q && state_q == ADDR_ACK && rw_q) begin
              oe_d     = ~reg_rdata[7];
              shreg_d  = {reg_rdata[6:0], 1'b0};
              bitcnt_d = 4'd1;
            end
          end
        RDATA:
          if (fall) begin
            if (bitcnt_q == 4'd8) begin
              oe_d     = 1'b0;
              bitcnt_d = '0;
              ph_d     = 1'b0;
            end else begin
              oe_d     = ~shreg_q[7];
              shreg_d  = {shreg_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        RDATA_ACK:
          if (rise && !ph_q) begin
            if (sda_s) begin
              busy_d = 1'b0;
              oe_d   = 1'b0;
            end else begin
              addr_d = addr_q + PTR_ONE;
              ph_d   = 1'b1;
            end
          end else if (fall && ph_q) begin
            oe_d     = ~reg_rdata[7];
            shreg_d  = {reg_rdata[6:0], 1'b0};
            bitcnt_d = 4'd1;
            ph_d     = 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Directed bench for i2c_target: bus-level controller tasks, a register
// bank model and a write-strobe log checked against hand-computed values.
module tb_i2c_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, busy;

  logic [7:0]  bank [256];
  logic [15:0] wlog [$];
  int          oe_cnt = 0, busy_cnt = 0, wr_long = 0;
  logic        wr_prev = 1'b0;
  int          passed = 0, total = 0;

  typedef struct {
    logic [7:0]  ptr, d0, d1;
    logic [15:0] e0, e1;
    logic [7:0]  efin;
  } wvec_t;

  wvec_t vecs [3];

  always #5 clk = ~clk;

  assign sda_in    = sda_m & ~sda_oe;
  assign reg_rdata = bank[reg_addr];

  i2c_target dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_in),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (reg_wr) wlog.push_back({reg_addr, reg_wdata});
    if (reg_wr && wr_prev) wr_long <= wr_long + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    wr_prev <= reg_wr;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = sda_in; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ack);
  endtask

  function automatic logic [31:0] logat(input int idx);
    if (idx < wlog.size()) return {16'h0, wlog[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic do_write(input wvec_t v, input string tag);
    logic ack;
    int   base;
    base = wlog.size();
    bus_start();
    wbyte(8'hA0, ack); check({tag, " ack_addr"}, ack, 0);
    check({tag, " busy"}, busy, 1);
    wbyte(v.ptr, ack); check({tag, " ack_ptr"}, ack, 0);
    wbyte(v.d0, ack);  check({tag, " ack_d0"}, ack, 0);
    wbyte(v.d1, ack);  check({tag, " ack_d1"}, ack, 0);
    bus_stop();
    check({tag, " wr_count"}, wlog.size() - base, 2);
    check({tag, " wr0"}, logat(base), {16'h0, v.e0});
    check({tag, " wr1"}, logat(base + 1), {16'h0, v.e1});
    check({tag, " final_addr"}, reg_addr, v.efin);
    check({tag, " busy_after_stop"}, busy, 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base, oe0, busy0;

    vecs[0] = '{8'h10, 8'hA5, 8'h3C, 16'h10A5, 16'h113C, 8'h12};
    vecs[1] = '{8'hFF, 8'h11, 8'h22, 16'hFF11, 16'h0022, 8'h01};
    vecs[2] = '{8'h7E, 8'h00, 8'hFF, 16'h7E00, 16'h7FFF, 8'h80};
    for (int i = 0; i < 256; i++) bank[i] = 8'(i ^ 8'h3C);
    bank[8'h20] = 8'h5A;
    bank[8'h21] = 8'hC3;
    bank[8'h30] = 8'h00;

    repeat (4) @(negedge clk);
    check("rst sda_oe", sda_oe, 0);
    check("rst reg_wr", reg_wr, 0);
    check("rst reg_addr", reg_addr, 0);
    check("rst reg_wdata", reg_wdata, 0);
    check("rst busy", busy, 0);
    rst = 1'b0;
    wq();

    for (int i = 0; i < 3; i++) do_write(vecs[i], $sformatf("wr%0d", i));

    // Read with repeated START
    base = wlog.size();
    bus_start();
    wbyte(8'hA0, ack); check("rd ack_addr_w", ack, 0);
    wbyte(8'h20, ack); check("rd ack_ptr", ack, 0);
    bus_start();
    wbyte(8'hA1, ack); check("rd ack_addr_r", ack, 0);
    rbyte(d, 1'b0);    check("rd byte0", d, 8'h5A);
    check("rd addr_after_ack", reg_addr, 8'h21);
    rbyte(d, 1'b1);    check("rd byte1", d, 8'hC3);
    check("rd busy_after_nack", busy, 0);
    check("rd sda_oe_after_nack", sda_oe, 0);
    bus_stop();
    check("rd addr_final", reg_addr, 8'h21);
    check("rd no_wr", wlog.size() - base, 0);

    // Wrong address
    base = wlog.size(); oe0 = oe_cnt; busy0 = busy_cnt;
    bus_start();
    wbyte(8'hA2, ack); check("bad nack_addr", ack, 1);
    wbyte(8'hFF, ack); check("bad nack_data", ack, 1);
    bus_stop();
    check("bad oe_never", oe_cnt - oe0, 0);
    check("bad no_wr", wlog.size() - base, 0);
    check("bad busy_never", busy_cnt - busy0, 0);

    // STOP in the middle of a data byte
    base = wlog.size();
    bus_start();
    wbyte(8'hA0, ack); check("mid ack_addr", ack, 0);
    wbyte(8'h05, ack); check("mid ack_ptr", ack, 0);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    bus_stop();
    check("mid no_wr", wlog.size() - base, 0);
    check("mid sda_oe", sda_oe, 0);
    check("mid reg_addr", reg_addr, 8'h05);
    check("mid busy", busy, 0);

    // Reset while the target is pulling SDA during a read
    bus_start();
    wbyte(8'hA0, ack); check("rr ack_addr_w", ack, 0);
    wbyte(8'h30, ack); check("rr ack_ptr", ack, 0);
    bus_start();
    wbyte(8'hA1, ack); check("rr ack_addr_r", ack, 0);
    check("rr oe_driving", sda_oe, 1);
    base = wlog.size();
    rst = 1'b1;
    #1;
    check("rr sda_oe", sda_oe, 0);
    check("rr reg_wr", reg_wr, 0);
    check("rr reg_addr", reg_addr, 0);
    check("rr reg_wdata", reg_wdata, 0);
    check("rr busy", busy, 0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wq();
    check("rr no_wr", wlog.size() - base, 0);
    do_write('{8'h40, 8'h99, 8'h77, 16'h4099, 16'h4177, 8'h42}, "post");

    check("wr_pulse_width", wr_long, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) port for the I2C test design; the responder end of the bus driven by the team's I2C controller. It filters and synchronises SCL/SDA, detects START/STOP, matches a 7-bit device address, and bridges bus transfers onto a simple byte-wide register interface with an auto-incrementing pointer. SDA is open-drain: the block only ever pulls low.

## Interface
- DEV_ADDR, 7'h50, 7-bit target address matched after START
- PTR_W, 8, register pointer / reg_addr width
- clk  in  1  system clock; rising-edge; must run ≥ 10× SCL rate
- rst  in  1  asynchronous, active-high reset
- scl_in  in  1  raw SCL pin level (asynchronous)
- sda_in  in  1  raw SDA pin level (asynchronous)
- sda_oe  out  1  1 = pull SDA low; 0 = release
- reg_addr  out  PTR_W  current register pointer
- reg_wdata  out  8  byte written by controller
- reg_wr  out  1  one-clk write strobe; reg_addr/reg_wdata valid with it
- reg_rdata  in  8  data at reg_addr, combinational from external bank
- busy  out  1  1 from address match until STOP/START/NACK-end

## Operation
- SCL/SDA each pass a 2-flop synchroniser, then a third flop for edge detection.
- START: SDA falling while SCL high. STOP: SDA rising while SCL high. Both override every state.
- Data bits sampled on synchronised SCL rising edge, MSB first; SDA driven/released only on SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: wait for START → ADDR (bit counter cleared).
- ADDR: shift 8 bits. On 8th bit: addr[7:1] == DEV_ADDR → ADDR_ACK, busy=1; else → IDLE, no ACK.
- ADDR_ACK: on next SCL fall assert sda_oe; on following SCL fall release. Then R/W=0 → PTR; R/W=1 → load shift reg from reg_rdata, → RDATA.
- PTR: 8 bits → reg_addr; PTR_ACK (ACK as above) → WDATA.
- WDATA: 8 bits → reg_wdata; reg_wr pulses one clk at the 8th SCL rise; WDATA_ACK (ACK); reg_addr increments on ACK release; → WDATA.
- RDATA: drive shift-reg MSB (sda_oe = ~bit) on each SCL fall, 8 bits; release after 8th bit → RDATA_ACK.
- RDATA_ACK: sample SDA on SCL rise. ACK (0): reg_addr increments, reload from reg_rdata on next SCL fall, → RDATA. NACK (1): → IDLE, busy=0, sda_oe=0.
- Repeated START in any state → ADDR, sda_oe=0, reg_addr retained. STOP → IDLE, sda_oe=0, busy=0, reg_addr retained.
- reg_addr wraps modulo 2^PTR_W (all-ones +1 → 0).

## Timing
- Reset (async): state IDLE, sda_oe=0, reg_wr=0, reg_addr=0, reg_wdata=0, busy=0, bit counter=0.
- Pin-to-event latency: 3 clk from raw SCL/SDA transition to detected edge/START/STOP.
- sda_oe changes 1 clk after detected SCL fall (≈4 clk after pin edge); within SCL low hold.
- reg_wr: exactly 1 clk high, 1 clk after 8th detected SCL rise of a data byte; never for pointer byte.
- reg_rdata sampled 1 clk after detected SCL fall; must be stable ≥ 1 clk after reg_addr change.
- Reset mid-transfer: bus released same clk as rst asserted; no reg_wr emitted.

## Test plan
- Write: START, 0xA0, 0x10, 0xA5, 0x3C, STOP → ACK on all 4 bytes; reg_wr at (0x10,0xA5) then (0x11,0x3C); reg_addr=0x12 after.
- Read with repeated START: START 0xA0 0x20, Sr 0xA1, read 2 bytes (ACK, NACK), STOP; bank[0x20]=0x5A, [0x21]=0xC3 → SDA bits 0x5A, 0xC3; busy=0 after NACK.
- Wrong address: START 0xA2 0xFF STOP → sda_oe never 1, no reg_wr, busy stays 0.
- Pointer wrap: ptr 0xFF, write 0x11, 0x22 → reg_wr (0xFF,0x11), (0x00,0x22).
- STOP mid-byte: START 0xA0 0x05, 4 data bits, STOP → no reg_wr, state IDLE, sda_oe=0, reg_addr=0x05.
- Reset during read while sda_oe=1 → sda_oe=0 and all outputs at reset values immediately; next full write transaction succeeds.
